fifo_ctrl_wm: RTL and testbench

//  Synchronous FIFO controller: read/write pointers, fill level, programmable watermarks, error flags.

---
 rtl/fifo_ctrl_wm_pkg.sv | 24 ++
 rtl/fifo_defs.vh | 15 +
 rtl/fifo_ptr.sv | 33 +++
 rtl/fifo_ctrl_wm.sv | 133 +++++++++++++
 tb/tb_fifo_ctrl_wm.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_ctrl_wm_pkg.sv
// rtl/fifo_ctrl_wm_pkg.sv - flag bundle type and flag evaluation for fifo_ctrl_wm
package fifo_ctrl_wm_pkg;

  typedef struct packed {
    logic full;
    logic afull;
    logic empty;
    logic aempty;
  } fifo_flags_t;

  // Evaluated on the post-edge level so the registered flags are exact, not lagging.
  function automatic fifo_flags_t calc_flags(input int unsigned lvl,
                                             input int unsigned depth,
                                             input int unsigned afull_th,
                                             input int unsigned aempty_th);
    fifo_flags_t f;
    f.full   = (lvl == depth);
    f.afull  = (lvl >= afull_th);
    f.empty  = (lvl == 0);
    f.aempty = (lvl <= aempty_th);
    return f;
  endfunction

endpackage

// File: rtl/fifo_defs.vh
// rtl/fifo_defs.vh - shared FIFO sizing macros and flag reset values
`ifndef FIFO_DEFS_VH
`define FIFO_DEFS_VH

`define FIFO_DEPTH(log) (1 << (log))
`define FIFO_PTR_W(log) ((log) + 1)

`define FIFO_RST_EMPTY  1'b1
`define FIFO_RST_AEMPTY 1'b1
`define FIFO_RST_FULL   1'b0
`define FIFO_RST_AFULL  1'b0
`define FIFO_RST_VALID  1'b0
`define FIFO_RST_ERR    1'b0

`endif

// File: rtl/fifo_ptr.sv
// rtl/fifo_ptr.sv - wrap-bit pointer with increment enable and async active-low reset
`include "fifo_defs.vh"

module fifo_ptr #(
  parameter int PTR_W = `FIFO_PTR_W(8)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [PTR_W-1:0] ptr_o
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) begin
      ptr_d = ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl_wm.sv
// rtl/fifo_ctrl_wm.sv - synchronous FIFO controller with watermarks and error flags
// Optional FIFO_ERR_STICKY_EN makes overflow/underflow sticky until err_clear.
`include "fifo_defs.vh"

module fifo_ctrl_wm
  import fifo_ctrl_wm_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH_LOG = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fifo_write_req,
  input  logic [WIDTH-1:0]     fifo_write_data,
  output logic                 fifo_full,
  output logic                 fifo_almost_full,
  input  logic                 fifo_read_req,
  output logic                 fifo_empty,
  output logic                 fifo_almost_empty,
  output logic                 fifo_read_valid,
  output logic [DEPTH_LOG:0]   fifo_level,
  input  logic [DEPTH_LOG:0]   cfg_afull_thresh,
  input  logic [DEPTH_LOG:0]   cfg_aempty_thresh,
  output logic                 fifo_overflow,
  output logic                 fifo_underflow,
  input  logic                 err_clear,
  output logic                 ram_write_req,
  output logic [DEPTH_LOG-1:0] ram_write_addr,
  output logic [WIDTH-1:0]     ram_write_data,
  output logic                 ram_read_req,
  output logic [DEPTH_LOG-1:0] ram_read_addr
);

  localparam int PTR_W = `FIFO_PTR_W(DEPTH_LOG);
  localparam int LVL_W = DEPTH_LOG + 2;
  localparam int DEPTH = `FIFO_DEPTH(DEPTH_LOG);

  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             rd_acc;
  logic             wr_acc;
  logic             ovf_evt;
  logic             unf_evt;
  logic [LVL_W-1:0] next_lvl;

  logic [PTR_W-1:0] level_q, level_d;
  fifo_flags_t      flags_q, flags_d;
  logic             rvalid_q, rvalid_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  fifo_ptr #(.PTR_W(PTR_W)) u_wptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (wr_acc),
    .ptr_o (wptr)
  );

  fifo_ptr #(.PTR_W(PTR_W)) u_rptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (rd_acc),
    .ptr_o (rptr)
  );

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign rd_acc  = fifo_read_req & ~flags_q.empty;
  assign wr_acc  = fifo_write_req & (~flags_q.full | rd_acc);
  assign ovf_evt = fifo_write_req & ~wr_acc;
  assign unf_evt = fifo_read_req & ~rd_acc;

  always_comb begin
    next_lvl = {1'b0, level_q} + LVL_W'(wr_acc) - LVL_W'(rd_acc);
    level_d  = next_lvl[PTR_W-1:0];
    flags_d  = calc_flags(32'(next_lvl), DEPTH, 32'(cfg_afull_thresh),
                          32'(cfg_aempty_thresh));
    rvalid_d = rd_acc;
  end

`ifdef FIFO_ERR_STICKY_EN
  always_comb begin
    ovf_d = ovf_evt | (ovf_q & ~err_clear);
    unf_d = unf_evt | (unf_q & ~err_clear);
  end
`else
  logic unused_err_clear;
  assign unused_err_clear = err_clear;

  always_comb begin
    ovf_d = ovf_evt;
    unf_d = unf_evt;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q        <= '0;
      flags_q.full   <= `FIFO_RST_FULL;
      flags_q.afull  <= `FIFO_RST_AFULL;
      flags_q.empty  <= `FIFO_RST_EMPTY;
      flags_q.aempty <= `FIFO_RST_AEMPTY;
      rvalid_q       <= `FIFO_RST_VALID;
      ovf_q          <= `FIFO_RST_ERR;
      unf_q          <= `FIFO_RST_ERR;
    end else begin
      level_q  <= level_d;
      flags_q  <= flags_d;
      rvalid_q <= rvalid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Wrap bits only disambiguate full/empty; the level register already does that.
  logic unused_ptr_msb;
  assign unused_ptr_msb = wptr[PTR_W-1] ^ rptr[PTR_W-1];

  assign fifo_full         = flags_q.full;
  assign fifo_almost_full  = flags_q.afull;
  assign fifo_empty        = flags_q.empty;
  assign fifo_almost_empty = flags_q.aempty;
  assign fifo_read_valid   = rvalid_q;
  assign fifo_level        = level_q;
  assign fifo_overflow     = ovf_q;
  assign fifo_underflow    = unf_q;

  assign ram_write_req  = wr_acc;
  assign ram_write_addr = wptr[DEPTH_LOG-1:0];
  assign ram_write_data = fifo_write_data;
  assign ram_read_req   = rd_acc;
  assign ram_read_addr  = rptr[DEPTH_LOG-1:0];

endmodule

// File: tb/tb_fifo_ctrl_wm.sv
// tb/tb_fifo_ctrl_wm.sv - randomized and directed check of fifo_ctrl_wm against a queue model
module tb_fifo_ctrl_wm;

  localparam int W  = 8;
  localparam int DL = 2;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fifo_write_req;
  logic [W-1:0]  fifo_write_data;
  logic          fifo_full;
  logic          fifo_almost_full;
  logic          fifo_read_req;
  logic          fifo_empty;
  logic          fifo_almost_empty;
  logic          fifo_read_valid;
  logic [DL:0]   fifo_level;
  logic [DL:0]   cfg_afull_thresh;
  logic [DL:0]   cfg_aempty_thresh;
  logic          fifo_overflow;
  logic          fifo_underflow;
  logic          err_clear;
  logic          ram_write_req;
  logic [DL-1:0] ram_write_addr;
  logic [W-1:0]  ram_write_data;
  logic          ram_read_req;
  logic [DL-1:0] ram_read_addr;

  always #5 clk = ~clk;

  fifo_ctrl_wm #(.WIDTH(W), .DEPTH_LOG(DL)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .fifo_write_req    (fifo_write_req),
    .fifo_write_data   (fifo_write_data),
    .fifo_full         (fifo_full),
    .fifo_almost_full  (fifo_almost_full),
    .fifo_read_req     (fifo_read_req),
    .fifo_empty        (fifo_empty),
    .fifo_almost_empty (fifo_almost_empty),
    .fifo_read_valid   (fifo_read_valid),
    .fifo_level        (fifo_level),
    .cfg_afull_thresh  (cfg_afull_thresh),
    .cfg_aempty_thresh (cfg_aempty_thresh),
    .fifo_overflow     (fifo_overflow),
    .fifo_underflow    (fifo_underflow),
    .err_clear         (err_clear),
    .ram_write_req     (ram_write_req),
    .ram_write_addr    (ram_write_addr),
    .ram_write_data    (ram_write_data),
    .ram_read_req      (ram_read_req),
    .ram_read_addr     (ram_read_addr)
  );

  // Stand-in for the external RAM: registered read, one cycle latency.
  logic [W-1:0] mem [D];
  logic [W-1:0] rdata;
  always @(posedge clk) begin
    if (ram_write_req) mem[ram_write_addr] <= ram_write_data;
    if (ram_read_req)  rdata <= mem[ram_read_addr];
  end

  int n_chk  = 0;
  int n_pass = 0;

  logic [W-1:0] mq [$];
  int           wcnt, rcnt;
  int           afth, aeth;
  bit           m_full, m_af, m_empty, m_ae, m_rv, m_ovf, m_unf;
  logic [W-1:0] exp_rd;
  logic [DL-1:0] s_waddr, s_raddr;
  logic          s_wreq;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    wcnt = 0; rcnt = 0;
    m_full = 0; m_af = 0; m_empty = 1; m_ae = 1;
    m_rv = 0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic check_regs();
    chk("level", 32'(fifo_level), mq.size());
    chk("full", 32'(fifo_full), 32'(m_full));
    chk("almost_full", 32'(fifo_almost_full), 32'(m_af));
    chk("empty", 32'(fifo_empty), 32'(m_empty));
    chk("almost_empty", 32'(fifo_almost_empty), 32'(m_ae));
    chk("read_valid", 32'(fifo_read_valid), 32'(m_rv));
    chk("overflow", 32'(fifo_overflow), 32'(m_ovf));
    chk("underflow", 32'(fifo_underflow), 32'(m_unf));
  endtask

  // Entered and left 1 time unit after a rising edge.
  task automatic cycle(input bit wr, input logic [W-1:0] wd, input bit rd, input bit clr = 1'b0);
    int  lvl;
    bit  racc, wacc, oe, ue;
    fifo_write_req    = wr;
    fifo_write_data   = wd;
    fifo_read_req     = rd;
    err_clear         = clr;
    cfg_afull_thresh  = afth[DL:0];
    cfg_aempty_thresh = aeth[DL:0];
    #3;
    lvl  = mq.size();
    racc = rd && (lvl > 0);
    wacc = wr && ((lvl < D) || racc);
    chk("ram_write_req", 32'(ram_write_req), 32'(wacc));
    chk("ram_read_req", 32'(ram_read_req), 32'(racc));
    if (wacc) begin
      chk("ram_write_addr", 32'(ram_write_addr), wcnt % D);
      chk("ram_write_data", 32'(ram_write_data), 32'(wd));
    end
    if (racc) chk("ram_read_addr", 32'(ram_read_addr), rcnt % D);
    s_waddr = ram_write_addr;
    s_raddr = ram_read_addr;
    s_wreq  = ram_write_req;
    @(posedge clk);
    #1;
    if (racc) begin exp_rd = mq.pop_front(); rcnt++; end
    if (wacc) begin mq.push_back(wd); wcnt++; end
    oe = wr && !wacc;
    ue = rd && !racc;
`ifdef FIFO_ERR_STICKY_EN
    m_ovf = oe || (m_ovf && !clr);
    m_unf = ue || (m_unf && !clr);
`else
    m_ovf = oe;
    m_unf = ue;
`endif
    m_rv    = racc;
    m_full  = (mq.size() == D);
    m_af    = (mq.size() >= afth);
    m_empty = (mq.size() == 0);
    m_ae    = (mq.size() <= aeth);
    check_regs();
    if (racc) chk("read_data", 32'(rdata), 32'(exp_rd));
  endtask

  initial begin
    rst_n = 1'b0;
    fifo_write_req = 0; fifo_write_data = '0; fifo_read_req = 0; err_clear = 0;
    afth = 3; aeth = 1;
    cfg_afull_thresh = 3'd3; cfg_aempty_thresh = 3'd1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: reset state and idle
    check_regs();
    chk("t1_empty_lit", 32'(fifo_empty), 1);
    cycle(0, 8'h00, 0);
    chk("t1_level_lit", 32'(fifo_level), 0);

    // 2: four writes fill the FIFO
    for (int i = 0; i < 4; i++) begin
      cycle(1, 8'hA1 + 8'(i), 0);
      chk("t2_waddr_lit", 32'(s_waddr), i);
      chk("t2_level_lit", 32'(fifo_level), i + 1);
      chk("t2_afull_lit", 32'(fifo_almost_full), (i >= 2) ? 1 : 0);
      chk("t2_full_lit", 32'(fifo_full), (i == 3) ? 1 : 0);
    end

    // 3: write and read together while full
    for (int i = 0; i < 2; i++) begin
      cycle(1, 8'hB0 + 8'(i), 1);
      chk("t3_raddr_lit", 32'(s_raddr), i);
      chk("t3_level_lit", 32'(fifo_level), 4);
      chk("t3_full_lit", 32'(fifo_full), 1);
      chk("t3_rvalid_lit", 32'(fifo_read_valid), 1);
      chk("t3_rdata_lit", 32'(rdata), 32'hA1 + i);
    end
    repeat (4) cycle(0, 8'h00, 1);
    cycle(0, 8'h00, 0);

    // 4: read while empty with a same-cycle write
    cycle(1, 8'h55, 1);
    chk("t4_unf_lit", 32'(fifo_underflow), 1);
    chk("t4_level_lit", 32'(fifo_level), 1);
    chk("t4_empty_lit", 32'(fifo_empty), 0);
    cycle(0, 8'h00, 1);

    // 5: write while full without a read
    for (int i = 0; i < 4; i++) cycle(1, 8'h60 + 8'(i), 0);
    cycle(1, 8'h77, 0);
    chk("t5_wreq_lit", 32'(s_wreq), 0);
    chk("t5_ovf_lit", 32'(fifo_overflow), 1);
    chk("t5_level_lit", 32'(fifo_level), 4);
    cycle(0, 8'h00, 0);
`ifdef FIFO_ERR_STICKY_EN
    chk("t5_ovf_hold_lit", 32'(fifo_overflow), 1);
`else
    chk("t5_ovf_pulse_lit", 32'(fifo_overflow), 0);
`endif
    cycle(0, 8'h00, 0, 1'b1);
    chk("t5_ovf_clr_lit", 32'(fifo_overflow), 0);
    repeat (4) cycle(0, 8'h00, 1);

    // 6: ten writes and ten reads across the wrap
    for (int i = 0; i < 10; i++) cycle(1, 8'(i * 7 + 3), i > 0);
    cycle(0, 8'h00, 1);
    cycle(0, 8'h00, 0);
    chk("t6_level_lit", 32'(fifo_level), 0);
    chk("t6_empty_lit", 32'(fifo_empty), 1);

    // Randomized traffic with wandering thresholds and error clears
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 31) == 0) begin
        afth = $urandom_range(0, 7);
        aeth = $urandom_range(0, 7);
      end
      cycle($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 45,
            $urandom_range(0, 9) == 0);
    end

    // 7: asynchronous reset mid-burst, then zero almost-full threshold
    afth = 0; aeth = 1;
    for (int i = 0; i < 3; i++) cycle(1, 8'hC0 + 8'(i), 0);
    fifo_write_req = 1; fifo_read_req = 1;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_regs();
    chk("t7_level_lit", 32'(fifo_level), 0);
    chk("t7_afull_lit", 32'(fifo_almost_full), 0);
    @(posedge clk);
    #1;
    check_regs();
    rst_n = 1'b1;
    cycle(0, 8'h00, 0);
    chk("t7_afull0_lit", 32'(fifo_almost_full), 1);
    for (int i = 0; i < 6; i++) cycle(1, 8'hD0 + 8'(i), i > 1);
    repeat (4) cycle(0, 8'h00, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
